// File: rtl/encoder_8b10b.sv
// 8b/10b symbol encoder with running-disparity tracking and registered output.
// Define ENCODER_CTRL_CHECK_EN to build the illegal-control-code flag on CtrlErr.
module encoder_8b10b #(
  parameter bit RD_RESET = 1'b0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       InVld,
  input  logic [7:0] Input,
  input  logic       Control,
  input  logic       BitRev,
  input  logic       InvertDataOut,
  output logic [9:0] Output,
  output logic       OutVld,
  output logic       DispOut,
  output logic       CtrlErr
);

  // RD- column of the 5b/6b table, written as abcdei (a is the MSB here)
  function automatic logic [5:0] tab6(input logic [4:0] x);
    logic [5:0] r;
    case (x)
      5'd0:  r = 6'b100111;  5'd1:  r = 6'b011101;  5'd2:  r = 6'b101101;  5'd3:  r = 6'b110001;
      5'd4:  r = 6'b110101;  5'd5:  r = 6'b101001;  5'd6:  r = 6'b011001;  5'd7:  r = 6'b111000;
      5'd8:  r = 6'b111001;  5'd9:  r = 6'b100101;  5'd10: r = 6'b010101;  5'd11: r = 6'b110100;
      5'd12: r = 6'b001101;  5'd13: r = 6'b101100;  5'd14: r = 6'b011100;  5'd15: r = 6'b010111;
      5'd16: r = 6'b011011;  5'd17: r = 6'b100011;  5'd18: r = 6'b010011;  5'd19: r = 6'b110010;
      5'd20: r = 6'b001011;  5'd21: r = 6'b101010;  5'd22: r = 6'b011010;  5'd23: r = 6'b111010;
      5'd24: r = 6'b110011;  5'd25: r = 6'b100110;  5'd26: r = 6'b010110;  5'd27: r = 6'b110110;
      5'd28: r = 6'b001110;  5'd29: r = 6'b101110;  5'd30: r = 6'b011110;  default: r = 6'b101011;
    endcase
    return r;
  endfunction

  // RD- column of the 3b/4b table, written as fghj (f is the MSB here)
  function automatic logic [3:0] tab4(input logic [2:0] y);
    logic [3:0] r;
    case (y)
      3'd0: r = 4'b1011;  3'd1: r = 4'b1001;  3'd2: r = 4'b0101;  3'd3: r = 4'b1100;
      3'd4: r = 4'b1101;  3'd5: r = 4'b1010;  3'd6: r = 4'b0110;  default: r = 4'b1110;
    endcase
    return r;
  endfunction

  logic       r_rd;
  logic [9:0] r_out;
  logic       r_vld;

  logic [4:0] w_x;
  logic [2:0] w_y;
  logic       w_k28;
  logic [5:0] w_6_neg, w_abcdei;
  logic       w_6_neu, w_rd_mid;
  logic       w_a7;
  logic [3:0] w_4_neg, w_fghj;
  logic       w_4_neu, w_4_cmp, w_rd_next;
  logic [9:0] w_sym, w_rev, w_tx;

  assign w_x   = Input[4:0];
  assign w_y   = Input[7:5];
  assign w_k28 = Control && (w_x == 5'd28);

  // D.7 is neutral yet still swaps to 000111 at RD+
  assign w_6_neg  = w_k28 ? 6'b001111 : tab6(w_x);
  assign w_6_neu  = ($countones(w_6_neg) == 3);
  assign w_abcdei = (r_rd && (!w_6_neu || w_x == 5'd7)) ? ~w_6_neg : w_6_neg;
  assign w_rd_mid = r_rd ^ !w_6_neu;

  assign w_a7 = (w_y == 3'd7) &&
                (Control ||
                 (!w_rd_mid && (w_x == 5'd17 || w_x == 5'd18 || w_x == 5'd20)) ||
                 ( w_rd_mid && (w_x == 5'd11 || w_x == 5'd13 || w_x == 5'd14)));
  assign w_4_neg = w_a7 ? 4'b0111 : tab4(w_y);
  assign w_4_neu = ($countones(w_4_neg) == 2);
  // K28 flips its neutral .1/.2/.5/.6 codes at intermediate RD- to keep the comma
  assign w_4_cmp = w_rd_mid ? (!w_4_neu || w_y == 3'd3)
                            : (w_k28 && w_4_neu && w_y != 3'd3);
  assign w_fghj   = w_4_cmp ? ~w_4_neg : w_4_neg;
  assign w_rd_next = w_rd_mid ^ !w_4_neu;

  assign w_sym = {w_fghj[0], w_fghj[1], w_fghj[2], w_fghj[3],
                  w_abcdei[0], w_abcdei[1], w_abcdei[2], w_abcdei[3], w_abcdei[4], w_abcdei[5]};

  always_comb begin
    w_rev = '0;
    for (int i = 0; i < 10; i++) w_rev[i] = w_sym[9-i];
  end

  assign w_tx = (BitRev ? w_rev : w_sym) ^ {10{InvertDataOut}};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_out <= '0;
      r_vld <= 1'b0;
      r_rd  <= RD_RESET;
    end else begin
      r_vld <= InVld;
      if (InVld) begin
        r_out <= w_tx;
        r_rd  <= w_rd_next;
      end
    end
  end

`ifdef ENCODER_CTRL_CHECK_EN
  logic r_err;
  logic w_k_legal;

  assign w_k_legal = w_k28 ||
                     (w_y == 3'd7 && (w_x == 5'd23 || w_x == 5'd27 || w_x == 5'd29 || w_x == 5'd30));

  always_ff @(posedge Clk) begin
    if (Reset) r_err <= 1'b0;
    else       r_err <= InVld && Control && !w_k_legal;
  end

  assign CtrlErr = r_err;
`else
  assign CtrlErr = 1'b0;
`endif

  assign Output  = r_out;
  assign OutVld  = r_vld;
  assign DispOut = r_rd;

endmodule

// File: tb/tb_encoder_8b10b.sv
// Bench for encoder_8b10b: table-driven reference model checked every cycle,
// plus hand-computed literal symbols from the standard code tables.
module tb_encoder_8b10b;

  logic       Clk = 1'b0;
  logic       Reset, InVld, Control, BitRev, InvertDataOut;
  logic [7:0] Input;
  logic [9:0] Output;
  logic       OutVld, DispOut, CtrlErr;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  encoder_8b10b dut (
    .Clk(Clk), .Reset(Reset), .InVld(InVld), .Input(Input), .Control(Control),
    .BitRev(BitRev), .InvertDataOut(InvertDataOut),
    .Output(Output), .OutVld(OutVld), .DispOut(DispOut), .CtrlErr(CtrlErr)
  );

  always #5 Clk = ~Clk;

  // Full two-column code tables, abcdei / fghj, leftmost letter as MSB
  localparam logic [5:0] N6 [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [5:0] P6 [32] = '{
    6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
    6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
    6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
  localparam logic [3:0] N4  [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [3:0] P4  [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
  localparam logic [3:0] KN4 [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  localparam logic [3:0] KP4 [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};

  // Returns {next RD, transmitted symbol}
  function automatic logic [10:0] enc(input logic [7:0] d, input logic k, input logic rd,
                                      input logic br, input logic inv);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] six;
    logic [3:0] four;
    logic       mid, nrd, a7;
    logic [9:0] s, t;
    x = d[4:0];
    y = d[7:5];
    six = rd ? P6[x] : N6[x];
    if (k && x == 5'd28) six = rd ? 6'b110000 : 6'b001111;
    mid = rd ^ ($countones(six) != 3);
    a7 = (y == 3'd7) && (k || (!mid && (x == 17 || x == 18 || x == 20)) ||
                               (mid && (x == 11 || x == 13 || x == 14)));
    if (k && x == 5'd28) four = mid ? KP4[y] : KN4[y];
    else if (a7)         four = mid ? 4'b1000 : 4'b0111;
    else                 four = mid ? P4[y] : N4[y];
    nrd = mid ^ ($countones(four) != 2);
    s = {four[0], four[1], four[2], four[3], six[0], six[1], six[2], six[3], six[4], six[5]};
    t = s;
    if (br) for (int i = 0; i < 10; i++) t[i] = s[9-i];
    return {nrd, t ^ {10{inv}}};
  endfunction

  function automatic logic k_legal(input logic [7:0] d);
    return (d[4:0] == 5'd28) ||
           (d[7:5] == 3'd7 && (d[4:0] == 23 || d[4:0] == 27 || d[4:0] == 29 || d[4:0] == 30));
  endfunction

  logic [9:0] m_out;
  logic       m_vld, m_rd, m_err;

  always @(posedge Clk) begin
    if (Reset) begin
      m_out <= '0; m_vld <= 1'b0; m_rd <= 1'b0; m_err <= 1'b0;
    end else begin
      m_vld <= InVld;
      if (InVld) {m_rd, m_out} <= enc(Input, Control, m_rd, BitRev, InvertDataOut);
`ifdef ENCODER_CTRL_CHECK_EN
      m_err <= InVld && Control && !k_legal(Input);
`else
      m_err <= 1'b0;
`endif
    end
  end

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("model_out",  Output,          m_out);
      chk("model_vld",  {9'd0, OutVld},  {9'd0, m_vld});
      chk("model_disp", {9'd0, DispOut}, {9'd0, m_rd});
      chk("model_err",  {9'd0, CtrlErr}, {9'd0, m_err});
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic k,
                       input logic br, input logic inv);
    InVld = v; Input = d; Control = k; BitRev = br; InvertDataOut = inv;
    @(posedge Clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [7:0] kcodes [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                              8'hF7, 8'hFB, 8'hFD, 8'hFE};

  initial begin
    Reset = 1'b1;
    drive(1'b1, 8'hBC, 1'b1, 1'b0, 1'b0);
    chk_en = 1'b1;
    chk("reset_out",  Output,          10'h000);
    chk("reset_vld",  {9'd0, OutVld},  10'h000);
    chk("reset_disp", {9'd0, DispOut}, 10'h000);
    Reset = 1'b0;

    drive(1'b1, 8'hBC, 1'b1, 1'b0, 1'b0);
    chk("k285_a", Output, 10'h17C);
    chk("k285_a_disp", {9'd0, DispOut}, 10'h001);
    chk("k285_a_vld",  {9'd0, OutVld},  10'h001);
    drive(1'b1, 8'hBC, 1'b1, 1'b0, 1'b0);
    chk("k285_b", Output, 10'h283);
    chk("k285_b_disp", {9'd0, DispOut}, 10'h000);
    drive(1'b1, 8'hBC, 1'b1, 1'b0, 1'b0);
    chk("k285_c", Output, 10'h17C);
    drive(1'b1, 8'hBC, 1'b1, 1'b0, 1'b0);  // back to RD-

    drive(1'b1, 8'hB5, 1'b0, 1'b0, 1'b0);
    chk("d21_5", Output, 10'h155);
    chk("d21_5_disp", {9'd0, DispOut}, 10'h000);
    drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("d0_0", Output, 10'h0B9);
    chk("d0_0_disp", {9'd0, DispOut}, 10'h000);
    drive(1'b1, 8'hF1, 1'b0, 1'b0, 1'b0);
    chk("d17_7_a7", Output, 10'h3B1);
    chk("d17_7_disp", {9'd0, DispOut}, 10'h001);

    drive(1'b1, 8'hBC, 1'b1, 1'b0, 1'b0);  // RD+ -> RD-
    drive(1'b1, 8'hBC, 1'b1, 1'b1, 1'b0);
    chk("bitrev", Output, 10'h0FA);
    drive(1'b1, 8'hBC, 1'b1, 1'b0, 1'b0);  // RD+ -> RD-
    drive(1'b1, 8'hBC, 1'b1, 1'b1, 1'b1);
    chk("bitrev_inv", Output, 10'h305);

    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
      chk("idle_hold", Output, 10'h305);
      chk("idle_vld",  {9'd0, OutVld},  10'h000);
      chk("idle_disp", {9'd0, DispOut}, 10'h001);
    end

    Reset = 1'b1;
    drive(1'b1, 8'hBC, 1'b1, 1'b0, 1'b0);
    Reset = 1'b0;
    chk("rst_mid_out",  Output,          10'h000);
    chk("rst_mid_vld",  {9'd0, OutVld},  10'h000);
    chk("rst_mid_disp", {9'd0, DispOut}, 10'h000);

    drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
`ifdef ENCODER_CTRL_CHECK_EN
    chk("ctrlerr_set", {9'd0, CtrlErr}, 10'h001);
`else
    chk("ctrlerr_tied", {9'd0, CtrlErr}, 10'h000);
`endif
    drive(1'b1, 8'hBC, 1'b1, 1'b0, 1'b0);
    chk("ctrlerr_clr", {9'd0, CtrlErr}, 10'h000);

    for (int i = 0; i < 256; i++) begin
      drive(($urandom_range(0, 7) != 0), i[7:0], 1'b0,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 12; i++) drive(1'b1, kcodes[i], 1'b1, 1'b0, 1'b0);
      drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 60; i++) begin
      drive(1'b1, 8'($urandom_range(0, 255)), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
